eight_bit_ripple_carry_adder: RTL and testbench
===============================================

Name:
eight_bit_ripple_carry_adder

Overview:
- Unsigned binary adder: a + b + cin, producing an N-bit sum and a carry-out.
- Built as a ripple chain of 1-bit full adders.
- Provides a combinational result and a registered copy. The registered copy lets the block drop into clocked datapaths, e.g. hash-round arithmetic in the blockchain accelerator.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1..64; default build is the 8-bit adder.

Ports:
- clk  input  1  single system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry-in to bit 0.
- sum  output  WIDTH  combinational sum, low WIDTH bits of a+b+cin.
- cout  output  1  combinational carry-out of the MSB stage.
- sum_q  output  WIDTH  registered sum.
- cout_q  output  1  registered carry-out.

Behaviour:
- Ripple chain:
  - c[0] = cin.
  - For each bit i: s[i] = a[i]^b[i]^c[i] and c[i+1] = (a[i]&b[i]) | (c[i]&(a[i]^b[i])).
  - cout = c[WIDTH].
- Arithmetic: {cout,sum} == a + b + cin exactly, as a (WIDTH+1)-bit unsigned result; no saturation; wrap modulo 2^WIDTH.
- Combinational path (sum/cout):
  - Zero-cycle latency; purely a function of a, b, cin.
  - Unaffected by clk and rst.
  - Must settle within one ripple delay of an input change; no latches.
- Registered path (sum_q/cout_q):
  - Captures sum/cout on every rising clk edge.
  - Latency: 1 cycle; no enable, no handshake; updates every cycle.
- Reset:
  - While rst=1: sum_q=0 and cout_q=0 immediately, with no clock needed.
  - Reset asserted mid-operation clears the registers asynchronously; sum/cout keep tracking inputs.
  - First capture after deassertion occurs on the first rising clk edge with rst=0.
- Boundary conditions:
  - All-ones + 0 + cin=1: sum=0, cout=1 (full carry propagation through every stage).
  - a=b=0, cin=0: sum=0, cout=0.
  - Max input 0xFF+0xFF+1: sum=0xFF, cout=1.
- X on any input propagates to the outputs; no X-masking.

Optional Feature:
- Macro: ADDER_OVERFLOW_EN.
- Defined:
  - Adds output ovf (1 bit, combinational) = c[WIDTH] ^ c[WIDTH-1], the two's-complement signed-overflow flag.
  - Adds ovf_q (1 bit), registered alongside sum_q with the same reset (0) and latency.
- Undefined: ovf and ovf_q ports do not exist; logic is identical otherwise.

Decomposition:
- Shared package adder_pkg:
  - localparam ADDER_DEFAULT_WIDTH = 8.
  - Typedef for the WIDTH+1 result word ({cout,sum}) used by the bench scoreboard.
- Sub-module full_adder (a, b, cin -> s, cout), purely combinational.
  - Instantiated WIDTH times via generate loop; carries chained stage to stage.
- Top level holds the chain plus the output register stage; no behavioural "+" operator in the DUT datapath.

Test Plan:
1. Reset: assert rst with a=9, b=9 -> sum_q=0, cout_q=0 immediately without a clock edge; sum=18 throughout.
2. Small sums, cin=0 (combinational, checked 1 time unit after apply):
   - 0+0 -> sum=0, cout=0.
   - 9+9 -> 18, cout=0.
   - 56+9 -> 65, cout=0.
   - 78+90 -> 168, cout=0.
   - 2+67 -> 69, cout=0.
3. Carry-out cases, cin=0:
   - 180+89 -> sum=13, cout=1.
   - 228+219 -> sum=191, cout=1.
   - 128+128 -> sum=0, cout=1.
4. Carry-in and full propagation:
   - 255+0+1 -> sum=0, cout=1.
   - 255+255+1 -> sum=255, cout=1.
   - 0+0+1 -> sum=1, cout=0.
5. Registered path:
   - Apply 78+90, clock once -> sum_q=168, cout_q=0.
   - Next cycle apply 180+89 -> sum_q=13, cout_q=1 after the next edge; sum_q holds 168 until that edge.
6. ADDER_OVERFLOW_EN build:
   - 127+1 -> ovf=1.
   - 128+128 -> ovf=1.
   - 100+20 -> ovf=0.
   - Random 1000 vectors checked against a (WIDTH+1)-bit golden model.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants and types for the ripple-carry adder and its bench.
package adder_pkg;

    localparam int ADDER_DEFAULT_WIDTH = 8;

    // Full result word {cout, sum} for the default-width adder.
    typedef logic [ADDER_DEFAULT_WIDTH:0] adder_result_t;

endpackage : adder_pkg

// File: rtl/full_adder.sv
// One-bit full adder stage: the cell the ripple chain is built from.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule : full_adder

// File: rtl/eight_bit_ripple_carry_adder.sv
// Parameterised ripple-carry adder with a combinational result and a registered copy.
// Define ADDER_OVERFLOW_EN to add the signed-overflow flag ovf and its registered copy ovf_q.
module eight_bit_ripple_carry_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [WIDTH-1:0] sum_q,
`ifdef ADDER_OVERFLOW_EN
    output logic             cout_q,
    output logic             ovf,
    output logic             ovf_q
`else
    output logic             cout_q
`endif
);

    // c[i] is the carry into stage i; c[WIDTH] leaves the MSB.
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (sum_d[i]),
            .cout (c[i+1])
        );
    end

    assign cout_d = c[WIDTH];
    assign sum    = sum_d;
    assign cout   = cout_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

`ifdef ADDER_OVERFLOW_EN
    // Signed overflow: carry into the sign bit differs from carry out of it.
    logic ovf_d;

    assign ovf_d = c[WIDTH] ^ c[WIDTH-1];
    assign ovf   = ovf_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end
`endif

endmodule : eight_bit_ripple_carry_adder

// File: tb/tb_eight_bit_ripple_carry_adder.sv
// Directed self-checking bench for eight_bit_ripple_carry_adder (default 8-bit build).
// Overflow checks are compiled in when ADDER_OVERFLOW_EN is defined.
module tb_eight_bit_ripple_carry_adder;
    import adder_pkg::*;

    localparam int W = ADDER_DEFAULT_WIDTH;

    logic         clk;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic [W-1:0] sum_q;
    logic         cout_q;
`ifdef ADDER_OVERFLOW_EN
    logic         ovf;
    logic         ovf_q;
`endif

    int tests_run;
    int tests_failed;

    adder_result_t exp_q[$];

    eight_bit_ripple_carry_adder #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .sum    (sum),
        .cout   (cout),
        .sum_q  (sum_q),
`ifdef ADDER_OVERFLOW_EN
        .cout_q (cout_q),
        .ovf    (ovf),
        .ovf_q  (ovf_q)
`else
        .cout_q (cout_q)
`endif
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: apply operands and let the combinational path settle.
    task automatic drive(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        a   = av;
        b   = bv;
        cin = cv;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(8'd9, 8'd9, 1'b0);
        tests_run++;
        if ({cout_q, sum_q} !== 9'd0) begin
            tests_failed++;
            $display("FAIL reset_initial: got %0d/%0d want 0/0", cout_q, sum_q);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if (sum_q !== 8'd18) begin
            tests_failed++;
            $display("FAIL reset_preload: sum_q got %0d want 18", sum_q);
        end
        // Assert reset between edges: registers must clear with no clock.
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        tests_run++;
        if ({cout_q, sum_q} !== 9'd0) begin
            tests_failed++;
            $display("FAIL reset_async: got %0d/%0d want 0/0", cout_q, sum_q);
        end
        tests_run++;
        if ({cout, sum} !== 9'd18) begin
            tests_failed++;
            $display("FAIL reset_comb: got %0d/%0d want 0/18", cout, sum);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_comb();
        logic [W-1:0]  va [11];
        logic [W-1:0]  vb [11];
        logic          vc [11];
        adder_result_t ve [11];
        va = '{8'd0, 8'd9, 8'd56, 8'd78, 8'd2, 8'd180, 8'd228, 8'd128, 8'd255, 8'd255, 8'd0};
        vb = '{8'd0, 8'd9, 8'd9, 8'd90, 8'd67, 8'd89, 8'd219, 8'd128, 8'd0, 8'd255, 8'd0};
        vc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        ve = '{9'd0, 9'd18, 9'd65, 9'd168, 9'd69, {1'b1, 8'd13}, {1'b1, 8'd191},
               {1'b1, 8'd0}, {1'b1, 8'd0}, {1'b1, 8'd255}, 9'd1};
        for (int i = 0; i < 11; i++) begin
            drive(va[i], vb[i], vc[i]);
            tests_run++;
            if ({cout, sum} !== ve[i]) begin
                tests_failed++;
                $display("FAIL comb_%0d: %0d+%0d+%0d got cout=%0d sum=%0d want cout=%0d sum=%0d",
                         i, va[i], vb[i], vc[i], cout, sum, ve[i][W], ve[i][W-1:0]);
            end
        end
    endtask

    task automatic test_registered();
        adder_result_t e;
        @(negedge clk);
        drive(8'd78, 8'd90, 1'b0);
        exp_q.push_back(9'd168);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        tests_run++;
        if ({cout_q, sum_q} !== e) begin
            tests_failed++;
            $display("FAIL reg_first: got %0d/%0d want %0d/%0d", cout_q, sum_q, e[W], e[W-1:0]);
        end
        @(negedge clk);
        drive(8'd180, 8'd89, 1'b0);
        exp_q.push_back({1'b1, 8'd13});
        tests_run++;
        if ({cout_q, sum_q} !== e) begin
            tests_failed++;
            $display("FAIL reg_hold: got %0d/%0d want %0d/%0d", cout_q, sum_q, e[W], e[W-1:0]);
        end
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        tests_run++;
        if ({cout_q, sum_q} !== e) begin
            tests_failed++;
            $display("FAIL reg_second: got %0d/%0d want %0d/%0d", cout_q, sum_q, e[W], e[W-1:0]);
        end
    endtask

`ifdef ADDER_OVERFLOW_EN
    task automatic test_overflow();
        logic [W-1:0] va [3];
        logic [W-1:0] vb [3];
        logic         vo [3];
        logic [W:0]   gold;
        logic         gold_ovf;
        va = '{8'd127, 8'd128, 8'd100};
        vb = '{8'd1, 8'd128, 8'd20};
        vo = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            drive(va[i], vb[i], 1'b0);
            tests_run++;
            if (ovf !== vo[i]) begin
                tests_failed++;
                $display("FAIL ovf_%0d: %0d+%0d got %0d want %0d", i, va[i], vb[i], ovf, vo[i]);
            end
        end
        @(negedge clk);
        drive(8'd127, 8'd1, 1'b0);
        @(posedge clk);
        #1;
        tests_run++;
        if (ovf_q !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_q: got %0d want 1", ovf_q);
        end
        for (int i = 0; i < 1000; i++) begin
            drive(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            gold     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            gold_ovf = (a[W-1] == b[W-1]) && (gold[W-1] != a[W-1]);
            tests_run++;
            if ({cout, sum} !== gold || ovf !== gold_ovf) begin
                tests_failed++;
                $display("FAIL rand_%0d: %0d+%0d+%0d got %0d ovf %0d want %0d ovf %0d",
                         i, a, b, cin, {cout, sum}, ovf, gold, gold_ovf);
            end
        end
    endtask
`endif

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst = 1'b1;
        a   = '0;
        b   = '0;
        cin = 1'b0;
        test_reset();
        test_comb();
        test_registered();
`ifdef ADDER_OVERFLOW_EN
        test_overflow();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_eight_bit_ripple_carry_adder
